spike_rate_decoder: RTL

//  Receive-side decoder for the neuron layer's spike outputs. Counts is_spike events per

---
 rtl/spike_rate_decoder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spike_rate_decoder.sv
// +--------------------------------------------------------------------------+
// | spike_rate_decoder: per-neuron spike counting over a window of valid     |
// | timesteps, valid/ready count stream and argmax winner report.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module spike_rate_decoder #(
  parameter  int N_NEURONS = 4,
  parameter  int CNT_W     = 8,
  localparam int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     window_len,
  input  logic                 spike_valid,
  input  logic [N_NEURONS-1:0] spike_in,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic [CNT_W-1:0]     out_count,
  output logic                 done,
  output logic [IDX_W-1:0]     winner_idx,
  output logic [CNT_W-1:0]     winner_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] step_q;
  logic [CNT_W-1:0] cnt_q [N_NEURONS];
  logic             busy_q;
  logic             out_valid_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             done_q;
  logic [IDX_W-1:0] max_idx_q;
  logic [CNT_W-1:0] max_cnt_q;
  logic [IDX_W-1:0] winner_idx_q;
  logic [CNT_W-1:0] winner_cnt_q;

  logic [CNT_W-1:0] step_d;
  logic [CNT_W-1:0] sel_cnt;
  logic             take_max;
  logic [IDX_W-1:0] max_idx_d;
  logic [CNT_W-1:0] max_cnt_d;

  assign step_d    = step_q + CNT_ONE;
  assign sel_cnt   = cnt_q[out_idx_q];
  // Strict '>' so an equal later count never displaces a lower index.
  assign take_max  = sel_cnt > max_cnt_q;
  assign max_idx_d = take_max ? out_idx_q : max_idx_q;
  assign max_cnt_d = take_max ? sel_cnt   : max_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      step_q       <= '0;
      for (int i = 0; i < N_NEURONS; i++) cnt_q[i] <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      done_q       <= 1'b0;
      max_idx_q    <= '0;
      max_cnt_q    <= '0;
      winner_idx_q <= '0;
      winner_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && (window_len != '0)) begin
            len_q     <= window_len;
            step_q    <= '0;
            for (int i = 0; i < N_NEURONS; i++) cnt_q[i] <= '0;
            max_idx_q <= '0;
            max_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (spike_valid) begin
            for (int i = 0; i < N_NEURONS; i++)
              cnt_q[i] <= cnt_q[i] + {{(CNT_W-1){1'b0}}, spike_in[i]};
            step_q <= step_d;
            if (step_d == len_q) begin
              out_valid_q <= 1'b1;
              out_idx_q   <= '0;
              state_q     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (out_valid_q && out_ready) begin
            max_idx_q <= max_idx_d;
            max_cnt_q <= max_cnt_d;
            if (out_idx_q == LAST_IDX) begin
              out_valid_q  <= 1'b0;
              out_idx_q    <= '0;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              winner_idx_q <= max_idx_d;
              winner_cnt_q <= max_cnt_d;
              state_q      <= S_IDLE;
            end else begin
              out_idx_q <= out_idx_q + IDX_ONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_count  = out_valid_q ? sel_cnt : '0;
  assign done       = done_q;
  assign winner_idx = winner_idx_q;
  assign winner_cnt = winner_cnt_q;

endmodule

`default_nettype wire
